// File: rtl/ksa_pkg.sv
// Shared Kogge-Stone helpers for the pipelined adder and subtractor.
//   gp_t       : {generate, propagate} pair for one bit or bit group
//   clog2      : ceiling log2, used to validate the LEVELS parameter
//   gp_combine : prefix operator; 'hi' is the more-significant group
package ksa_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return int'(r);
  endfunction

  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    return '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};
  endfunction

endpackage

// File: rtl/ksa_prefix_stage.sv
// One registered Kogge-Stone prefix level.
//   Bits i >= DIST combine with bit i-DIST; lower bits pass through.
//   A side-band vector rides along untouched so the caller can keep
//   per-operation data aligned with the prefix pipeline.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  load enable (pipeline advance)
//   in_valid/out_valid  stage valid bit
//   in_g/in_p           generate/propagate into this level
//   out_g/out_p         registered generate/propagate after this level
//   in_side/out_side    registered pass-through side-band data
module ksa_prefix_stage
  import ksa_pkg::*;
#(
  parameter int          BITS   = 64,
  parameter int unsigned DIST   = 1,
  parameter int          SIDE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [BITS-1:0]   in_g,
  input  logic [BITS-1:0]   in_p,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  output logic [BITS-1:0]   out_g,
  output logic [BITS-1:0]   out_p,
  output logic [SIDE_W-1:0] out_side
);

  logic [BITS-1:0] nxt_g;
  logic [BITS-1:0] nxt_p;
  gp_t             comb;

  always_comb begin
    nxt_g = in_g;
    nxt_p = in_p;
    comb  = '0;
    for (int unsigned i = DIST; i < BITS; i++) begin
      comb     = gp_combine('{g: in_g[i], p: in_p[i]},
                            '{g: in_g[i-DIST], p: in_p[i-DIST]});
      nxt_g[i] = comb.g;
      nxt_p[i] = comb.p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_g     <= '0;
      out_p     <= '0;
      out_side  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_g     <= nxt_g;
      out_p     <= nxt_p;
      out_side  <= in_side;
    end
  end

endmodule

// File: rtl/ksa_sub_pipe.sv
// Pipelined Kogge-Stone subtractor: d = a - b - bin, computed as
// a + ~b + !bin. d[BITS] is the borrow out (inverted carry out).
// Stages: S0 operand register, LEVELS prefix levels, output register.
// Latency LEVELS+2 cycles, one operation per cycle, whole-pipe stall on
// backpressure (bubbles are kept, not squeezed).
// Optional macro KSA_SUB_FLAGS_EN adds the flags port {ovf, neg, zero},
// registered together with d.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_ready = !out_valid | out_ready
//   a, b, bin            minuend, subtrahend, borrow in
//   out_valid/out_ready  result handshake
//   d                    {borrow_out, difference}
//   flags                {ovf, neg, zero} (KSA_SUB_FLAGS_EN only)
module ksa_sub_pipe
  import ksa_pkg::*;
#(
  parameter int BITS   = 64,
  parameter int LEVELS = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS:0]   d
`ifdef KSA_SUB_FLAGS_EN
  ,
  output logic [2:0]      flags
`endif
);

  // Side-band: [BITS-1:0] bitwise half-sum, [BITS] carry in,
  // and with flags also [BITS+1] b msb, [BITS+2] a msb.
`ifdef KSA_SUB_FLAGS_EN
  localparam int SIDE_W = BITS + 3;
`else
  localparam int SIDE_W = BITS + 1;
`endif

  if (LEVELS != clog2(BITS)) begin : g_levels_check
    $error("ksa_sub_pipe: LEVELS must equal clog2(BITS)");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S0 operand register
  logic            s0_valid;
  logic [BITS-1:0] s0_a;
  logic [BITS-1:0] s0_b;
  logic            s0_bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_bin   <= 1'b0;
    end else if (adv) begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_a   <= a;
        s0_b   <= b;
        s0_bin <= bin;
      end
    end
  end

  // Initial generate/propagate. The carry in is folded into bit 0's
  // generate so every group generate G[i] is the true carry out of bit i.
  logic [BITS-1:0]   g0;
  logic [BITS-1:0]   p0;
  logic [BITS-1:0]   nb;
  logic              cin0;
  logic [SIDE_W-1:0] side0;

  always_comb begin
    nb    = ~s0_b;
    p0    = s0_a ^ nb;
    g0    = s0_a & nb;
    cin0  = !s0_bin;
    g0[0] = g0[0] | (p0[0] & cin0);
`ifdef KSA_SUB_FLAGS_EN
    side0 = {s0_a[BITS-1], s0_b[BITS-1], cin0, p0};
`else
    side0 = {cin0, p0};
`endif
  end

  logic              lvl_valid [LEVELS+1];
  logic [BITS-1:0]   lvl_g     [LEVELS+1];
  logic [BITS-1:0]   lvl_p     [LEVELS+1];
  logic [SIDE_W-1:0] lvl_side  [LEVELS+1];

  assign lvl_valid[0] = s0_valid;
  assign lvl_g[0]     = g0;
  assign lvl_p[0]     = p0;
  assign lvl_side[0]  = side0;

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    ksa_prefix_stage #(
      .BITS  (BITS),
      .DIST  (1 << l),
      .SIDE_W(SIDE_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (adv),
      .in_valid (lvl_valid[l]),
      .in_g     (lvl_g[l]),
      .in_p     (lvl_p[l]),
      .in_side  (lvl_side[l]),
      .out_valid(lvl_valid[l+1]),
      .out_g    (lvl_g[l+1]),
      .out_p    (lvl_p[l+1]),
      .out_side (lvl_side[l+1])
    );
  end

  // Sum/output stage: carry into bit i is G[i-1], into bit 0 the carry in.
  logic [BITS-1:0] fin_g;
  logic [BITS-1:0] fin_x;
  logic            fin_cin;
  logic [BITS-1:0] carries;
  logic [BITS-1:0] sum;

  assign fin_g   = lvl_g[LEVELS];
  assign fin_x   = lvl_side[LEVELS][BITS-1:0];
  assign fin_cin = lvl_side[LEVELS][BITS];
  assign carries = {fin_g[BITS-2:0], fin_cin};
  assign sum     = fin_x ^ carries;

`ifdef KSA_SUB_FLAGS_EN
  logic fin_am;
  logic fin_bm;
  assign fin_am = lvl_side[LEVELS][BITS+2];
  assign fin_bm = lvl_side[LEVELS][BITS+1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      d         <= '0;
`ifdef KSA_SUB_FLAGS_EN
      flags     <= '0;
`endif
    end else if (adv) begin
      out_valid <= lvl_valid[LEVELS];
      if (lvl_valid[LEVELS]) begin
        d     <= {!fin_g[BITS-1], sum};
`ifdef KSA_SUB_FLAGS_EN
        flags <= {(fin_am != fin_bm) && (sum[BITS-1] != fin_am),
                  sum[BITS-1],
                  sum == '0};
`endif
      end
    end
  end

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Self-checking bench for ksa_sub_pipe (BITS=64, LEVELS=6).
// A queue-based arithmetic model predicts every result; a negedge
// compare process checks each valid output, the handshake relation and
// stall stability; directed vectors pin the model with literal values.
// Flag checks are compiled in when KSA_SUB_FLAGS_EN is defined.
module tb_ksa_sub_pipe;

  localparam int BITS = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            bin;
  logic            out_valid;
  logic            out_ready;
  logic [BITS:0]   d;
`ifdef KSA_SUB_FLAGS_EN
  logic [2:0]      flags;
`endif

  int checks = 0;
  int errors = 0;
  int recv_cnt = 0;

  logic [67:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [64:0] prev_d = '0;

  ksa_sub_pipe #(
    .BITS  (BITS),
    .LEVELS(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d)
`ifdef KSA_SUB_FLAGS_EN
    ,
    .flags    (flags)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // {ovf, neg, zero, borrow, difference} from plain integer arithmetic
  function automatic logic [67:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                        input logic mbin);
    logic [64:0]        diff;
    logic signed [65:0] s;
    logic               ovf;
    diff = {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
    s    = $signed({{2{ma[63]}}, ma}) - $signed({{2{mb[63]}}, mb}) - $signed({65'd0, mbin});
    ovf  = (s > 66'sd9223372036854775807) || (s < -66'sd9223372036854775808);
    return {ovf, diff[63], diff[63:0] == 64'd0, diff};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_adv", 68'(in_ready), 68'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("hold_valid", 68'(out_valid), 68'd1);
        chk("hold_d", 68'(d), 68'(prev_d));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 68'(out_valid), 68'd0);
        end else begin
`ifdef KSA_SUB_FLAGS_EN
          chk("result", {flags, d}, exp_q[0]);
`else
          chk("result", 68'(d), 68'(exp_q[0][64:0]));
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            recv_cnt++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
      prev_stall = out_valid && !out_ready;
      prev_d     = d;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] da, input logic [63:0] db,
                       input logic dbin);
    in_valid = v;
    a        = da;
    b        = db;
    bin      = dbin;
  endtask

  task automatic single(input string name, input logic [63:0] sa, input logic [63:0] sb,
                        input logic sbin, input logic [64:0] exp_d, input logic [2:0] exp_f);
    int n;
    out_ready = 1'b1;
    drive(1'b1, sa, sb, sbin);
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_latency"}, 68'(n), 68'd8);
    chk({name, "_d"}, 68'(d), 68'(exp_d));
`ifdef KSA_SUB_FLAGS_EN
    chk({name, "_flags"}, 68'(flags), 68'(exp_f));
`else
    if (exp_f == 3'b111) $display("note: unused flag vector");
`endif
    step();
    chk({name, "_pulse"}, 68'(out_valid), 68'd0);
  endtask

  initial begin
    int sent;
    int guard;
    int r0;
    int n;
    logic acc;
    logic [64:0] hd;

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    chk("reset_out_valid", 68'(out_valid), 68'd0);
    chk("reset_d", 68'(d), 68'd0);
    chk("reset_in_ready", 68'(in_ready), 68'd1);
    step();

    // directed vectors
    single("v_5_3", 64'd5, 64'd3, 1'b0, 65'h0_0000_0000_0000_0002, 3'b000);
    single("v_3_5", 64'd3, 64'd5, 1'b0, 65'h1_FFFF_FFFF_FFFF_FFFE, 3'b010);
    single("v_0_0_b", 64'd0, 64'd0, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF, 3'b010);
    single("v_min_1", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 65'h0_7FFF_FFFF_FFFF_FFFF, 3'b100);
    single("v_zero", 64'd0, 64'd0, 1'b0, 65'h0_0000_0000_0000_0000, 3'b001);
    single("v_ff_ff_b", '1, '1, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF, 3'b010);

    // random stream with toggling backpressure
    r0 = recv_cnt;
    sent = 0;
    guard = 0;
    drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    while (sent < 20 && guard < 500) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      step();
      guard++;
      if (acc) begin
        sent++;
        if (sent < 20)
          drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
    end
    chk("stream_accepted", 68'(sent), 68'd20);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("stream_drained", 68'(exp_q.size()), 68'd0);
    chk("stream_count", 68'(recv_cnt - r0), 68'd20);
    step();

    // fill with 8 ops, stall 10 cycles, then drain
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 64'(k * 1000 + 7), 64'(k * 3), 1'(k % 2));
      step();
    end
    in_valid = 1'b0;
    chk("fill_out_valid", 68'(out_valid), 68'd1);
    hd = d;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_d", 68'(d), 68'(hd));
      chk("stall_out_valid", 68'(out_valid), 68'd1);
      chk("stall_in_ready", 68'(in_ready), 68'd0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", 68'(out_valid), 68'd1);
      step();
    end
    chk("drain_done", 68'(out_valid), 68'd0);

    // reset with 5 ops in flight
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 64'(k + 100), 64'(k), 1'b0);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_out_valid", 68'(out_valid), 68'd0);
    chk("midreset_d", 68'(d), 68'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("midreset_no_stale", 68'(out_valid), 68'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
